// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, tag type and round-robin pick function for the multiplier scheduler
package mul_pkg;
    localparam int MUL_W       = 64;
    localparam int PROD_W      = 128;
    localparam int MUL_LAT_DEF = 2;
    localparam int MAX_REQ     = 16;
    localparam int TAG_ID_W    = 4;
    localparam int IDX_W       = TAG_ID_W + 1;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

    // First valid index at or after ptr, wrapping modulo n; returns ptr when nothing is valid
    function automatic logic [TAG_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                    input logic [TAG_ID_W-1:0] ptr,
                                                    input int n);
        logic [IDX_W-1:0] idx;
        logic found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(n)) idx = idx - IDX_W'(n);
            if (i < n && !found && valid[idx[TAG_ID_W-1:0]]) begin
                rr_pick = idx[TAG_ID_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/mul_rr_scheduler_if.sv
// mul_rr_scheduler_if: requester, multiplier and response signals of the shared multiplier scheduler
interface mul_rr_scheduler_if import mul_pkg::*; #(parameter int N_REQ = 4);
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ*MUL_W-1:0] req_a_i;
    logic [N_REQ*MUL_W-1:0] req_b_i;
    logic [MUL_W-1:0]       mul_a_o;
    logic [MUL_W-1:0]       mul_b_o;
    logic [PROD_W-1:0]      mul_p_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [ID_W-1:0]        rsp_id_o;
    logic [PROD_W-1:0]      rsp_data_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, mul_p_i, rsp_ready_i,
        input  req_ready_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, mul_p_i, rsp_ready_i,
        output req_ready_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );
endinterface

// File: rtl/mul_rsp_fifo.sv
// mul_rsp_fifo: sync FIFO of {id, product} whose head is held in output registers
module mul_rsp_fifo import mul_pkg::*; #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ID_W-1:0]   push_id,
    input  logic [PROD_W-1:0] push_data,
    input  logic              pop,
    output logic              head_vld,
    output logic [ID_W-1:0]   head_id,
    output logic [PROD_W-1:0] head_data
);
    localparam int W  = ID_W + PROD_W;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   cnt;
    logic          take, from_mem, bypass, to_mem;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head reloads when empty or popped; an empty backing store lets a push go straight to the head
    always_comb begin
        take     = !head_vld || pop;
        from_mem = take && cnt != '0;
        bypass   = take && cnt == '0 && push;
        to_mem   = push && !bypass;
    end

    // Backing store write, no reset needed since cnt qualifies every entry
    always_ff @(posedge clk) begin
        if (to_mem) mem[wr_ptr] <= {push_id, push_data};
    end

    // Pointers, occupancy and registered head; id/data keep their last value when the FIFO drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            head_vld  <= 1'b0;
            head_id   <= '0;
            head_data <= '0;
        end else begin
            if (to_mem) wr_ptr <= inc(wr_ptr);
            if (from_mem) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + (PW+1)'(to_mem) - (PW+1)'(from_mem);
            if (take) head_vld <= from_mem || bypass;
            if (from_mem) {head_id, head_data} <= mem[rd_ptr];
            else if (bypass) {head_id, head_data} <= {push_id, push_data};
        end
    end
endmodule

// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin sharing of one pipelined multiplier with credit flow control; MUL_RR_PERF_CNT_EN adds issue/stall counters
module mul_rr_scheduler import mul_pkg::*; #(
    parameter int N_REQ     = 4,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_rr_scheduler_if.slave  bus
`ifdef MUL_RR_PERF_CNT_EN
    ,
    output logic [31:0]        perf_issue_o,
    output logic [31:0]        perf_stall_o
`endif
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int CW   = $clog2(RSP_DEPTH + 1);

    logic [ID_W-1:0]     rr_ptr, grant;
    logic [TAG_ID_W-1:0] pick;
    logic [CW-1:0]       credits;
    logic                hs, pop;
    mul_tag_t            tag [MUL_LAT];

    // Grant, handshake and operand mux; nothing is accepted while reset is asserted
    always_comb begin
        pick            = rr_pick(MAX_REQ'(bus.req_valid_i), TAG_ID_W'(rr_ptr), N_REQ);
        grant           = pick[ID_W-1:0];
        hs              = rst_n && |bus.req_valid_i && credits != '0;
        pop             = bus.rsp_valid_o && bus.rsp_ready_i;
        bus.req_ready_o = hs ? N_REQ'(1) << grant : '0;
        bus.mul_a_o     = hs ? bus.req_a_i[MUL_W*grant +: MUL_W] : '0;
        bus.mul_b_o     = hs ? bus.req_b_i[MUL_W*grant +: MUL_W] : '0;
    end

    // Round-robin pointer, free-slot credits and the tag pipe that tracks products through the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            credits <= CW'(RSP_DEPTH);
            for (int i = 0; i < MUL_LAT; i++) tag[i] <= '0;
        end else begin
            if (hs) rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            credits <= credits - CW'(hs) + CW'(pop);
            tag[0]  <= '{vld: hs, id: TAG_ID_W'(grant)};
            for (int i = 1; i < MUL_LAT; i++) tag[i] <= tag[i-1];
        end
    end

    mul_rsp_fifo #(.ID_W(ID_W), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag[MUL_LAT-1].vld),
        .push_id   (tag[MUL_LAT-1].id[ID_W-1:0]),
        .push_data (bus.mul_p_i),
        .pop       (pop),
        .head_vld  (bus.rsp_valid_o),
        .head_id   (bus.rsp_id_o),
        .head_data (bus.rsp_data_o)
    );

`ifdef MUL_RR_PERF_CNT_EN
    // Wrapping counters of handshakes and of cycles where requests wait on credits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_o <= '0;
            perf_stall_o <= '0;
        end else begin
            perf_issue_o <= perf_issue_o + 32'(hs);
            perf_stall_o <= perf_stall_o + 32'(|bus.req_valid_i && credits == '0);
        end
    end
`endif
endmodule
